// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage definitions: reset/trap vectors, NOP encoding and the
// {pc, instr} pair carried between fetch, skid buffer and IF/ID.
package fetch_unit_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEF  = 32'h0000_0000;
    localparam logic [XLEN-1:0] TRAP_VEC_DEF  = 32'h0000_0040;
    localparam logic [XLEN-1:0] NOP_INSTR_DEF = 32'h0000_0013;
    localparam int              IMEM_AW_DEF   = 5;

    typedef enum logic {
        RUN  = 1'b0,
        HELD = 1'b1
    } skid_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_pair_t;

    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return low_bits != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: control from decode/EX, instruction memory side and the
// IF/ID register outputs. The fetch unit is the master.
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic            stall_in;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rst;
    logic [XLEN-1:0] imem_rdata;
    logic            if_id_valid;
    logic [XLEN-1:0] if_id_pc;
    logic [XLEN-1:0] if_id_pc_plus4;
    logic [XLEN-1:0] if_id_instr;
    logic            misaligned_exc;
    logic [XLEN-1:0] misaligned_pc;

    modport master (
        input  stall_in, redirect_valid, redirect_pc, imem_rdata,
        output imem_addr, imem_rst, if_id_valid, if_id_pc, if_id_pc_plus4,
               if_id_instr, misaligned_exc, misaligned_pc
    );

    modport slave (
        output stall_in, redirect_valid, redirect_pc, imem_rdata,
        input  imem_addr, imem_rst, if_id_valid, if_id_pc, if_id_pc_plus4,
               if_id_instr, misaligned_exc, misaligned_pc
    );

endinterface

// File: rtl/fetch_unit_skid_buf.sv
// One-entry {pc, instr} buffer that catches the memory word arriving while
// decode is stalled. Clear wins over load.
module fetch_skid_buf
    import fetch_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        clear,
    input  fetch_pair_t din,
    output fetch_pair_t dout,
    output logic        valid
);

    fetch_pair_t data_q;
    logic        valid_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (clear) begin
            valid_q <= 1'b0;
        end else if (load) begin
            data_q  <= din;
            valid_q <= 1'b1;
        end
    end

    assign dout  = data_q;
    assign valid = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC generation, pairing of the registered memory word with
// its PC, IF/ID register with a one-entry skid buffer, and redirect handling.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [XLEN-1:0] TRAP_VEC  = TRAP_VEC_DEF,
    parameter int              IMEM_AW   = IMEM_AW_DEF,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
)(
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] f_pc_q;
    logic            f_valid_q;
    skid_state_t     state;

    logic            if_id_valid_q;
    logic [XLEN-1:0] if_id_pc_q;
    logic [XLEN-1:0] if_id_pc_plus4_q;
    logic [XLEN-1:0] if_id_instr_q;
    logic            misaligned_exc_q;
    logic [XLEN-1:0] misaligned_pc_q;

    logic            redirect_mis;
    logic [XLEN-1:0] redirect_target;
    logic            skid_load;
    logic            skid_clear;
    logic            skid_valid;
    fetch_pair_t     skid_in;
    fetch_pair_t     skid_out;

    always_comb begin
        redirect_mis    = is_misaligned(bus.redirect_pc[1:0]);
        redirect_target = redirect_mis ? TRAP_VEC : bus.redirect_pc;
    end

    assign skid_in.pc    = f_pc_q;
    assign skid_in.instr = bus.imem_rdata;
    assign skid_load  = !bus.redirect_valid && (state == RUN) && bus.stall_in && f_valid_q;
    assign skid_clear = bus.redirect_valid || ((state == HELD) && !bus.stall_in);

    fetch_skid_buf u_skid (
        .clk   (clk),
        .rst   (rst),
        .load  (skid_load),
        .clear (skid_clear),
        .din   (skid_in),
        .dout  (skid_out),
        .valid (skid_valid)
    );

    // While stalled with an empty fetch slot (just after reset or a redirect)
    // the PC still steps once, so pc_q stays one word ahead of f_pc_q and the
    // word caught by the skid buffer is never fetched twice.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q             <= RESET_PC;
            f_pc_q           <= RESET_PC;
            f_valid_q        <= 1'b0;
            state            <= RUN;
            if_id_valid_q    <= 1'b0;
            if_id_pc_q       <= '0;
            if_id_pc_plus4_q <= 32'd4;
            if_id_instr_q    <= NOP_INSTR;
            misaligned_exc_q <= 1'b0;
            misaligned_pc_q  <= '0;
        end else begin
            misaligned_exc_q <= 1'b0;
            if (bus.redirect_valid) begin
                pc_q          <= redirect_target;
                f_valid_q     <= 1'b0;
                state         <= RUN;
                if_id_valid_q <= 1'b0;
                if_id_instr_q <= NOP_INSTR;
                if (redirect_mis) begin
                    misaligned_exc_q <= 1'b1;
                    misaligned_pc_q  <= bus.redirect_pc;
                end
            end else begin
                f_pc_q    <= pc_q;
                f_valid_q <= 1'b1;
                case (state)
                    RUN: begin
                        if (!bus.stall_in) begin
                            pc_q          <= pc_q + 32'd4;
                            if_id_valid_q <= f_valid_q;
                            if (f_valid_q) begin
                                if_id_pc_q       <= f_pc_q;
                                if_id_pc_plus4_q <= f_pc_q + 32'd4;
                                if_id_instr_q    <= bus.imem_rdata;
                            end else begin
                                if_id_instr_q <= NOP_INSTR;
                            end
                        end else if (!f_valid_q) begin
                            pc_q <= pc_q + 32'd4;
                        end else begin
                            state <= HELD;
                        end
                    end
                    HELD: begin
                        if (!bus.stall_in) begin
                            if_id_valid_q    <= skid_valid;
                            if_id_pc_q       <= skid_out.pc;
                            if_id_pc_plus4_q <= skid_out.pc + 32'd4;
                            if_id_instr_q    <= skid_out.instr;
                            pc_q             <= pc_q + 32'd4;
                            state            <= RUN;
                        end
                    end
                    default: state <= RUN;
                endcase
            end
        end
    end

    assign bus.imem_addr      = {{(XLEN - IMEM_AW){1'b0}}, pc_q[IMEM_AW+1:2]};
    assign bus.imem_rst       = ~rst;
    assign bus.if_id_valid    = if_id_valid_q;
    assign bus.if_id_pc       = if_id_pc_q;
    assign bus.if_id_pc_plus4 = if_id_pc_plus4_q;
    assign bus.if_id_instr    = if_id_instr_q;
    assign bus.misaligned_exc = misaligned_exc_q;
    assign bus.misaligned_pc  = misaligned_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed stall/redirect/reset vectors push
// expected IF/ID contents; a negedge monitor pops and compares them.
module tb_fetch_unit;

    typedef struct {
        logic        v;
        logic [31:0] pc;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    exp_t exp_q[$];
    exp_t last_exp;
    logic samp_rst;
    logic samp_stall;
    logic samp_redir;

    fetch_unit_if bus();

    fetch_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memory, word i holds 0x1000_0000 + i, active-high reset.
    always @(posedge clk) begin
        if (bus.imem_rst) bus.imem_rdata <= 32'h0;
        else              bus.imem_rdata <= 32'h1000_0000 + {27'b0, bus.imem_addr[4:0]};
    end

    function automatic logic [31:0] mem_word(input logic [31:0] pc);
        return 32'h1000_0000 + ((pc >> 2) & 32'h1F);
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic s, input logic r, input logic [31:0] rpc,
                                  input logic ev, input logic [31:0] epc);
        exp_t e;
        bus.stall_in       = s;
        bus.redirect_valid = r;
        bus.redirect_pc    = rpc;
        if (r || !s) begin
            e.v  = ev;
            e.pc = epc;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.redirect_valid = 1'b0;
    endtask

    task automatic check_reset_values();
        check_output("rst_valid", {31'b0, bus.if_id_valid}, 32'd0);
        check_output("rst_pc", bus.if_id_pc, 32'd0);
        check_output("rst_pc_plus4", bus.if_id_pc_plus4, 32'd4);
        check_output("rst_instr", bus.if_id_instr, 32'h13);
        check_output("rst_exc", {31'b0, bus.misaligned_exc}, 32'd0);
        check_output("rst_mis_pc", bus.misaligned_pc, 32'd0);
        check_output("rst_imem_addr", bus.imem_addr, 32'd0);
    endtask

    always @(posedge clk) begin
        samp_rst   = rst;
        samp_stall = bus.stall_in;
        samp_redir = bus.redirect_valid;
    end

    // Advancing edges consume one expected entry; stalled edges must hold.
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b1 && samp_rst === 1'b1) begin
            if (samp_redir || !samp_stall) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_advance: got pc %h with no expected entry", bus.if_id_pc);
                end else begin
                    e = exp_q.pop_front();
                    last_exp = e;
                    check_output("ifid_valid", {31'b0, bus.if_id_valid}, {31'b0, e.v});
                    if (e.v) begin
                        check_output("ifid_pc", bus.if_id_pc, e.pc);
                        check_output("ifid_pc_plus4", bus.if_id_pc_plus4, e.pc + 32'd4);
                        check_output("ifid_instr", bus.if_id_instr, mem_word(e.pc));
                    end else begin
                        check_output("ifid_nop", bus.if_id_instr, 32'h13);
                    end
                end
            end else begin
                check_output("hold_valid", {31'b0, bus.if_id_valid}, {31'b0, last_exp.v});
                if (last_exp.v) check_output("hold_pc", bus.if_id_pc, last_exp.pc);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        checks             = 0;
        errors             = 0;
        last_exp.v         = 1'b0;
        last_exp.pc        = 32'h0;
        rst                = 1'b0;
        bus.stall_in       = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values();
        rst = 1'b1;

        // Straight-line fetch from reset.
        apply_stimulus(0, 0, 0, 0, 32'h0);
        apply_stimulus(0, 0, 0, 1, 32'h0);
        apply_stimulus(0, 0, 0, 1, 32'h4);
        apply_stimulus(0, 0, 0, 1, 32'h8);

        // Three-cycle stall with pc 8 in IF/ID.
        repeat (3) apply_stimulus(1, 0, 0, 0, 32'h0);
        apply_stimulus(0, 0, 0, 1, 32'hC);
        apply_stimulus(0, 0, 0, 1, 32'h10);
        apply_stimulus(0, 0, 0, 1, 32'h14);

        // Aligned redirect to 0x20.
        apply_stimulus(0, 1, 32'h20, 0, 32'h0);
        apply_stimulus(0, 0, 0, 0, 32'h0);
        apply_stimulus(0, 0, 0, 1, 32'h20);
        apply_stimulus(0, 0, 0, 1, 32'h24);

        // Redirect while HELD and stalled: flush wins over the skid entry.
        apply_stimulus(1, 0, 0, 0, 32'h0);
        apply_stimulus(1, 0, 0, 0, 32'h0);
        apply_stimulus(1, 1, 32'h20, 0, 32'h0);
        apply_stimulus(1, 0, 0, 0, 32'h0);
        apply_stimulus(1, 0, 0, 0, 32'h0);
        apply_stimulus(0, 0, 0, 1, 32'h20);
        apply_stimulus(0, 0, 0, 1, 32'h24);

        // Misaligned redirect traps to 0x40.
        apply_stimulus(0, 1, 32'h22, 0, 32'h0);
        check_output("exc_pulse", {31'b0, bus.misaligned_exc}, 32'd1);
        check_output("exc_pc", bus.misaligned_pc, 32'h22);
        check_output("trap_imem_addr", bus.imem_addr, 32'h10);
        apply_stimulus(0, 0, 0, 0, 32'h0);
        check_output("exc_drop", {31'b0, bus.misaligned_exc}, 32'd0);
        check_output("exc_pc_held", bus.misaligned_pc, 32'h22);
        apply_stimulus(0, 0, 0, 1, 32'h40);
        apply_stimulus(0, 0, 0, 1, 32'h44);

        // Reset while HELD with a full skid buffer, then fetch past the wrap.
        apply_stimulus(1, 0, 0, 0, 32'h0);
        rst          = 1'b0;
        bus.stall_in = 1'b0;
        #1;
        check_reset_values();
        @(posedge clk);
        #1;
        rst         = 1'b1;
        last_exp.v  = 1'b0;
        last_exp.pc = 32'h0;
        apply_stimulus(0, 0, 0, 0, 32'h0);
        for (int n = 0; n <= 32; n++) begin
            apply_stimulus(0, 0, 0, 1, 32'(4 * n));
            if (n == 29) check_output("addr_top", bus.imem_addr, 32'd31);
            if (n == 30) check_output("addr_wrap", bus.imem_addr, 32'd0);
        end

        @(negedge clk);
        #1;
        check_output("queue_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
